// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command frame parser driving a req/ack bus master
// Bytes from the sclk-domain receiver are synchronised, decoded and turned into 17-bit bus transactions.
module spi_cmd_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_cs_n,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic [7:0]  spi_tx,
  output logic        bus_req,
  output logic        bus_rw_b,
  output logic [16:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  input  logic [7:0]  bus_rd_data,
  input  logic        bus_ack,
  output logic        busy,
  output logic        cmd_err
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_AHI  = 4'd1,
    ST_ALO  = 4'd2,
    ST_DATA = 4'd3,
    ST_REQ  = 4'd4,
    ST_SKIP = 4'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   done_prev_q, done_prev_d;
  state_t                 state_q, state_d;
  logic                   is_read_q, is_read_d;
  logic [16:0]            addr_q, addr_d;
  logic [16:0]            last_addr_q, last_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   req_q, req_d;
  logic [7:0]             tmo_cnt_q, tmo_cnt_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [7:0]             spi_tx_q, spi_tx_d;
  logic                   tx_hold_q, tx_hold_d;

  logic cs_s, done_s, byte_ev, cs_rise, cs_fall;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    done_sync_d = {done_sync_q[SYNC_STAGES-2:0], spi_done};
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    done_s      = done_sync_q[SYNC_STAGES-1];
    byte_ev     = done_s & ~done_prev_q;
    cs_rise     = cs_s & ~cs_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
    cs_prev_d   = cs_s;
    done_prev_d = done_s;

    state_d     = state_q;
    is_read_d   = is_read_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    wr_data_d   = wr_data_q;
    req_d       = req_q;
    tmo_cnt_d   = tmo_cnt_q;
    cmd_err_d   = cmd_err_q;
    spi_tx_d    = spi_tx_q;
    tx_hold_d   = tx_hold_q;

    // A frame start clears the error before any byte arriving in the same cycle can set it again.
    if (cs_fall) cmd_err_d = 1'b0;
    if (byte_ev) tx_hold_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_ev && !cs_rise) begin
          case (spi_rx[7:4])
            4'h0: ;
            4'h1, 4'h2: begin
              is_read_d  = (spi_rx[7:4] == 4'h2);
              addr_d[16] = spi_rx[0];
              state_d    = ST_AHI;
            end
            4'h3: begin
              is_read_d = 1'b0;
              addr_d    = last_addr_q + 17'd1;
              state_d   = ST_DATA;
            end
            4'h4: begin
              is_read_d = 1'b1;
              addr_d    = last_addr_q + 17'd1;
              state_d   = ST_REQ;
            end
            default: begin
              cmd_err_d = 1'b1;
              state_d   = ST_SKIP;
            end
          endcase
        end
      end
      ST_AHI: begin
        if (cs_rise) state_d = ST_IDLE;
        else if (byte_ev) begin
          addr_d[15:8] = spi_rx;
          state_d      = ST_ALO;
        end
      end
      ST_ALO: begin
        if (cs_rise) state_d = ST_IDLE;
        else if (byte_ev) begin
          addr_d[7:0] = spi_rx;
          state_d     = is_read_q ? ST_REQ : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cs_rise) state_d = ST_IDLE;
        else if (byte_ev) begin
          wr_data_d = spi_rx;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // Bytes arriving here are overruns; a frame abort waits for the handshake to finish.
        if (byte_ev) cmd_err_d = 1'b1;
        if (!req_q) begin
          req_d     = 1'b1;
          tmo_cnt_d = 8'd0;
        end else if (bus_ack) begin
          req_d       = 1'b0;
          last_addr_d = addr_q;
          state_d     = ST_IDLE;
          if (is_read_q) begin
            tx_hold_d = 1'b1;
            spi_tx_d  = bus_rd_data;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          req_d     = 1'b0;
          cmd_err_d = 1'b1;
          tx_hold_d = 1'b1;
          spi_tx_d  = 8'hEE;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_SKIP: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!tx_hold_d) spi_tx_d = {(state_d == ST_REQ), cmd_err_d, 2'b00, state_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= '1;
      done_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      done_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      is_read_q   <= 1'b0;
      addr_q      <= 17'h0;
      last_addr_q <= 17'h0;
      wr_data_q   <= 8'h00;
      req_q       <= 1'b0;
      tmo_cnt_q   <= 8'd0;
      cmd_err_q   <= 1'b0;
      spi_tx_q    <= 8'h00;
      tx_hold_q   <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      done_sync_q <= done_sync_d;
      cs_prev_q   <= cs_prev_d;
      done_prev_q <= done_prev_d;
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      wr_data_q   <= wr_data_d;
      req_q       <= req_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cmd_err_q   <= cmd_err_d;
      spi_tx_q    <= spi_tx_d;
      tx_hold_q   <= tx_hold_d;
    end
  end

  assign spi_tx      = spi_tx_q;
  assign bus_req     = req_q;
  assign bus_rw_b    = is_read_q;
  assign bus_addr    = addr_q;
  assign bus_wr_data = wr_data_q;
  assign busy        = (state_q == ST_REQ);
  assign cmd_err     = cmd_err_q;

endmodule
